// File: rtl/wb_stage_pkg.sv
// Shared CPU package: datapath defaults, branch-type encodings and the
// writeback squash-state enum used by the decoder, EX/WB register and WB stage.
package wb_stage_pkg;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_RD_W         = 6;
  localparam int DEF_FLUSH_CYCLES = 3;

  localparam logic BTYPE_ZERO = 1'b0;
  localparam logic BTYPE_NEG  = 1'b1;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// EX/WB pipeline-register bundle as seen by the writeback stage.
interface wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 6
) ();

  logic              in_valid;
  logic              in_ctrl_regwrt;
  logic              in_ctrl_branch;
  logic              in_ctrl_btype;
  logic              in_ctrl_jump;
  logic              in_ctrl_memtoreg;
  logic              in_ctrl_neg;
  logic              in_ctrl_zero;
  logic [DATA_W-1:0] in_memdata;
  logic [DATA_W-1:0] in_aluresult;
  logic [DATA_W-1:0] in_target;
  logic [RD_W-1:0]   in_rd;

  modport master (
    output in_valid, in_ctrl_regwrt, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump,
    output in_ctrl_memtoreg, in_ctrl_neg, in_ctrl_zero,
    output in_memdata, in_aluresult, in_target, in_rd
  );

  modport slave (
    input in_valid, in_ctrl_regwrt, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump,
    input in_ctrl_memtoreg, in_ctrl_neg, in_ctrl_zero,
    input in_memdata, in_aluresult, in_target, in_rd
  );

endinterface

// File: rtl/wb_stage_branch_resolve.sv
// Combinational branch/jump outcome: the branch type picks which ALU flag
// decides a conditional branch; the other flag is ignored.
module branch_resolve
  import wb_stage_pkg::*;
(
  input  logic branch,
  input  logic btype,
  input  logic jump,
  input  logic neg,
  input  logic zero,
  output logic taken
);

  logic cond_s;

  // Select the flag tested by the conditional branch
  always_comb begin
    cond_s = 1'b0;
    if (btype == BTYPE_NEG) begin
      cond_s = neg;
    end else begin
      cond_s = zero;
    end
  end

  assign taken = jump | (branch & cond_s);

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: register-file write port, PC redirect on taken branches/jumps,
// wrong-path squash FSM and a retired-instruction counter.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RD_W         = DEF_RD_W,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  wb_stage_if.slave         bus,
  output logic              rf_wr_en,
  output logic [RD_W-1:0]   rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              squashing,
  output logic [31:0]       retired
);

  wb_state_e         state_r;
  wb_state_e         state_next_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_next_s;
  logic              taken_s;
  logic              accept_s;
  logic [DATA_W-1:0] wb_data_s;

  logic              rf_wr_en_r;
  logic [RD_W-1:0]   rf_wr_addr_r;
  logic [DATA_W-1:0] rf_wr_data_r;
  logic              redirect_r;
  logic [DATA_W-1:0] redirect_pc_r;
  logic              squashing_r;
  logic [31:0]       retired_r;

  branch_resolve u_branch_resolve (
    .branch (bus.in_ctrl_branch),
    .btype  (bus.in_ctrl_btype),
    .jump   (bus.in_ctrl_jump),
    .neg    (bus.in_ctrl_neg),
    .zero   (bus.in_ctrl_zero),
    .taken  (taken_s)
  );

  assign accept_s  = bus.in_valid & (state_r == RUN);
  assign wb_data_s = bus.in_ctrl_memtoreg ? bus.in_memdata : bus.in_aluresult;

  // Squash FSM next state; bubbles do not consume squash slots
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      RUN: begin
        if (accept_s && taken_s && (FLUSH_CYCLES > 0)) begin
          state_next_s = FLUSH;
          cnt_next_s   = 4'(FLUSH_CYCLES);
        end else begin
          state_next_s = RUN;
          cnt_next_s   = cnt_r;
        end
      end
      FLUSH: begin
        if (bus.in_valid) begin
          cnt_next_s = cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_next_s = RUN;
          end else begin
            state_next_s = FLUSH;
          end
        end else begin
          state_next_s = FLUSH;
          cnt_next_s   = cnt_r;
        end
      end
      default: begin
        state_next_s = RUN;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // State, output registers and retired counter; strobes pulse, payloads hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= RUN;
      cnt_r         <= 4'd0;
      rf_wr_en_r    <= 1'b0;
      rf_wr_addr_r  <= '0;
      rf_wr_data_r  <= '0;
      redirect_r    <= 1'b0;
      redirect_pc_r <= '0;
      squashing_r   <= 1'b0;
      retired_r     <= 32'd0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      squashing_r <= (state_next_s == FLUSH);
      rf_wr_en_r  <= accept_s & bus.in_ctrl_regwrt;
      redirect_r  <= accept_s & taken_s;
      if (accept_s) begin
        rf_wr_addr_r <= bus.in_rd;
        rf_wr_data_r <= wb_data_s;
        retired_r    <= retired_r + 32'd1;
      end
      if (accept_s && taken_s) begin
        redirect_pc_r <= bus.in_target;
      end
    end
  end

  assign rf_wr_en    = rf_wr_en_r;
  assign rf_wr_addr  = rf_wr_addr_r;
  assign rf_wr_data  = rf_wr_data_r;
  assign redirect    = redirect_r;
  assign redirect_pc = redirect_pc_r;
  assign squashing   = squashing_r;
  assign retired     = retired_r;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a chained vector table plus hand-written
// sequences for the squash window, reset mid-flush, counter wrap and no-flush build.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if #(.DATA_W(32), .RD_W(6)) bus ();
  wb_stage_if #(.DATA_W(32), .RD_W(6)) bus0 ();

  logic        rf_wr_en, redirect, squashing;
  logic [5:0]  rf_wr_addr;
  logic [31:0] rf_wr_data, redirect_pc, retired;

  logic        rf_wr_en0, redirect0, squashing0;
  logic [5:0]  rf_wr_addr0;
  logic [31:0] rf_wr_data0, redirect_pc0, retired0;

  wb_stage #(.DATA_W(32), .RD_W(6), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .squashing(squashing),
    .retired(retired)
  );

  wb_stage #(.DATA_W(32), .RD_W(6), .FLUSH_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .rf_wr_en(rf_wr_en0), .rf_wr_addr(rf_wr_addr0), .rf_wr_data(rf_wr_data0),
    .redirect(redirect0), .redirect_pc(redirect_pc0), .squashing(squashing0),
    .retired(retired0)
  );

  typedef struct {
    logic        valid, regwrt, branch, btype, jump, memtoreg, neg, zero;
    logic [5:0]  rd;
    logic [31:0] memdata, alu, target;
    logic        e_en;
    logic [5:0]  e_addr;
    logic [31:0] e_data;
    logic        e_red;
    logic [31:0] e_pc;
    logic        e_sq;
    logic [31:0] e_ret;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, regwrt, branch, btype, jump, memtoreg, neg, zero,
                       input logic [5:0] rd, input logic [31:0] memdata, alu, target);
    bus.in_valid = valid;         bus.in_ctrl_regwrt = regwrt;
    bus.in_ctrl_branch = branch;  bus.in_ctrl_btype = btype;
    bus.in_ctrl_jump = jump;      bus.in_ctrl_memtoreg = memtoreg;
    bus.in_ctrl_neg = neg;        bus.in_ctrl_zero = zero;
    bus.in_rd = rd;               bus.in_memdata = memdata;
    bus.in_aluresult = alu;       bus.in_target = target;
    @(negedge clk);
  endtask

  // ALU-style bundle helper for the hand sequences
  task automatic op(input logic valid, regwrt, branch, btype, jump, neg, zero,
                    input logic [5:0] rd, input logic [31:0] alu, target);
    drive(valid, regwrt, branch, btype, jump, 1'b0, neg, zero, rd, 32'h0, alu, target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
    op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    bus0.in_valid = 1'b0;       bus0.in_ctrl_regwrt = 1'b0; bus0.in_ctrl_branch = 1'b0;
    bus0.in_ctrl_btype = 1'b0;  bus0.in_ctrl_jump = 1'b0;   bus0.in_ctrl_memtoreg = 1'b0;
    bus0.in_ctrl_neg = 1'b0;    bus0.in_ctrl_zero = 1'b0;   bus0.in_rd = 6'd0;
    bus0.in_memdata = 32'h0;    bus0.in_aluresult = 32'h0;  bus0.in_target = 32'h0;

    //          vl    wr    br    bt    jp    m2r   neg   zero  rd     memdata        alu            target         en    addr   data           red   pc             sq    ret
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd5,  32'h0,         32'h0000_00AA, 32'h0,         1'b1, 6'd5,  32'h0000_00AA, 1'b0, 32'h0,         1'b0, 32'd1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd63, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0,         1'b1, 6'd63, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 32'd2};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd7,  32'h0,         32'h0000_1234, 32'h0,         1'b0, 6'd63, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 32'd2};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd3,  32'h0,         32'h0000_0005, 32'h0000_0080, 1'b0, 6'd3,  32'h0000_0005, 1'b0, 32'h0,         1'b0, 32'd3};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1,  32'h0,         32'h0000_0104, 32'h0000_0100, 1'b1, 6'd1,  32'h0000_0104, 1'b1, 32'h0000_0100, 1'b1, 32'd4};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd9,  32'h0,         32'h0000_0099, 32'h0,         1'b0, 6'd1,  32'h0000_0104, 1'b0, 32'h0000_0100, 1'b1, 32'd4};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd10, 32'h0,         32'h0000_00AB, 32'h0000_0200, 1'b0, 6'd1,  32'h0000_0104, 1'b0, 32'h0000_0100, 1'b1, 32'd4};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd11, 32'h0,         32'h0000_00BC, 32'h0,         1'b0, 6'd1,  32'h0000_0104, 1'b0, 32'h0000_0100, 1'b0, 32'd4};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  32'h0,         32'h0000_0055, 32'h0,         1'b1, 6'd0,  32'h0000_0055, 1'b0, 32'h0000_0100, 1'b0, 32'd5};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd2,  32'h0,         32'h0000_0007, 32'h0000_0240, 1'b0, 6'd2,  32'h0000_0007, 1'b0, 32'h0000_0100, 1'b0, 32'd6};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd4,  32'h0,         32'h0000_0008, 32'h0000_0300, 1'b0, 6'd4,  32'h0000_0008, 1'b1, 32'h0000_0300, 1'b1, 32'd7};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd13, 32'h0,         32'h0000_0001, 32'h0,         1'b0, 6'd4,  32'h0000_0008, 1'b0, 32'h0000_0300, 1'b1, 32'd7};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd14, 32'h0,         32'h0000_0002, 32'h0,         1'b0, 6'd4,  32'h0000_0008, 1'b0, 32'h0000_0300, 1'b1, 32'd7};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd15, 32'h0,         32'h0000_0003, 32'h0,         1'b0, 6'd4,  32'h0000_0008, 1'b0, 32'h0000_0300, 1'b1, 32'd7};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd16, 32'h0,         32'h0000_0004, 32'h0,         1'b0, 6'd4,  32'h0000_0008, 1'b0, 32'h0000_0300, 1'b0, 32'd7};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd17, 32'h0,         32'h0000_0066, 32'h0,         1'b1, 6'd17, 32'h0000_0066, 1'b0, 32'h0000_0300, 1'b0, 32'd8};

    do_reset();
    check("reset wr_en",     {31'd0, rf_wr_en}, 32'd0);
    check("reset wr_addr",   {26'd0, rf_wr_addr}, 32'd0);
    check("reset wr_data",   rf_wr_data, 32'd0);
    check("reset redirect",  {31'd0, redirect}, 32'd0);
    check("reset pc",        redirect_pc, 32'd0);
    check("reset squashing", {31'd0, squashing}, 32'd0);
    check("reset retired",   retired, 32'd0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].valid, vecs[i].regwrt, vecs[i].branch, vecs[i].btype, vecs[i].jump,
            vecs[i].memtoreg, vecs[i].neg, vecs[i].zero, vecs[i].rd,
            vecs[i].memdata, vecs[i].alu, vecs[i].target);
      check($sformatf("v%0d wr_en", i),     {31'd0, rf_wr_en}, {31'd0, vecs[i].e_en});
      check($sformatf("v%0d wr_addr", i),   {26'd0, rf_wr_addr}, {26'd0, vecs[i].e_addr});
      check($sformatf("v%0d wr_data", i),   rf_wr_data, vecs[i].e_data);
      check($sformatf("v%0d redirect", i),  {31'd0, redirect}, {31'd0, vecs[i].e_red});
      check($sformatf("v%0d pc", i),        redirect_pc, vecs[i].e_pc);
      check($sformatf("v%0d squashing", i), {31'd0, squashing}, {31'd0, vecs[i].e_sq});
      check($sformatf("v%0d retired", i),   retired, vecs[i].e_ret);
    end

    // BRZ, then write / bubble / write / write squashed, fourth write lands
    do_reset();
    op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 32'h0, 32'h0000_0040);
    check("brz redirect", {31'd0, redirect}, 32'd1);
    check("brz pc",       redirect_pc, 32'h0000_0040);
    check("brz squash",   {31'd0, squashing}, 32'd1);
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd20, 32'h0000_0001, 32'h0);
    check("sq1 wr_en",    {31'd0, rf_wr_en}, 32'd0);
    check("sq1 redirect", {31'd0, redirect}, 32'd0);
    op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd20, 32'h0000_0002, 32'h0);
    check("bubble squash", {31'd0, squashing}, 32'd1);
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd20, 32'h0000_0003, 32'h0);
    check("sq2 wr_en",  {31'd0, rf_wr_en}, 32'd0);
    check("sq2 squash", {31'd0, squashing}, 32'd1);
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd20, 32'h0000_0004, 32'h0);
    check("sq3 wr_en",  {31'd0, rf_wr_en}, 32'd0);
    check("sq3 squash", {31'd0, squashing}, 32'd0);
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd21, 32'h0000_0021, 32'h0);
    check("w4 wr_en",   {31'd0, rf_wr_en}, 32'd1);
    check("w4 wr_addr", {26'd0, rf_wr_addr}, 32'd21);
    check("w4 wr_data", rf_wr_data, 32'h0000_0021);
    check("w4 retired", retired, 32'd2);

    // Reset while flushing with two slots left
    op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0000_0080);
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd22, 32'h0000_0022, 32'h0);
    check("pre-rst squash", {31'd0, squashing}, 32'd1);
    rst = 1'b1;
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd23, 32'h0000_0023, 32'h0000_0090);
    rst = 1'b0;
    check("rst squash",   {31'd0, squashing}, 32'd0);
    check("rst retired",  retired, 32'd0);
    check("rst wr_en",    {31'd0, rf_wr_en}, 32'd0);
    check("rst redirect", {31'd0, redirect}, 32'd0);
    check("rst pc",       redirect_pc, 32'd0);
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd12, 32'h0000_0077, 32'h0);
    check("post-rst wr_en",   {31'd0, rf_wr_en}, 32'd1);
    check("post-rst wr_addr", {26'd0, rf_wr_addr}, 32'd12);
    check("post-rst wr_data", rf_wr_data, 32'h0000_0077);
    check("post-rst retired", retired, 32'd1);

    // Retired counter wrap
    force dut.retired_r = 32'hFFFF_FFFE;
    op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 32'h0);
    release dut.retired_r;
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd24, 32'h0000_0024, 32'h0);
    check("wrap max", retired, 32'hFFFF_FFFF);
    op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd25, 32'h0000_0025, 32'h0);
    check("wrap zero", retired, 32'd0);

    // No-flush build: a jump redirects and the next bundle is accepted
    do_reset();
    bus0.in_valid = 1'b1; bus0.in_ctrl_jump = 1'b1; bus0.in_ctrl_regwrt = 1'b0;
    bus0.in_target = 32'h0000_0500;
    @(negedge clk);
    check("nf redirect", {31'd0, redirect0}, 32'd1);
    check("nf pc",       redirect_pc0, 32'h0000_0500);
    check("nf squash",   {31'd0, squashing0}, 32'd0);
    bus0.in_ctrl_jump = 1'b0; bus0.in_ctrl_regwrt = 1'b1;
    bus0.in_rd = 6'd3; bus0.in_aluresult = 32'h0000_0033;
    @(negedge clk);
    check("nf wr_en",    {31'd0, rf_wr_en0}, 32'd1);
    check("nf wr_data",  rf_wr_data0, 32'h0000_0033);
    check("nf redirect2", {31'd0, redirect0}, 32'd0);
    check("nf retired",  retired0, 32'd2);
    bus0.in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
